// File: rtl/bsg_nasti_pkg.sv
// bsg_nasti_pkg: tunnel request/response type and read/write classifier
package bsg_nasti_pkg;
  typedef enum logic {e_nasti_read = 1'b0, e_nasti_write = 1'b1} bsg_nasti_op_e;
  typedef struct packed {
    bsg_nasti_op_e op;
    logic [31:0] addr;
    logic [31:0] data;
  } bsg_tun_dmx_t;
  function automatic logic bsg_nasti_req_is_read(bsg_tun_dmx_t req);
    return req.op == e_nasti_read;
  endfunction
endpackage

// File: rtl/bsg_nasti_arb_id_fifo.sv
// bsg_nasti_arb_id_fifo: in-order tag FIFO holding the source id of each outstanding read
module bsg_nasti_arb_id_fifo
  import bsg_nasti_pkg::*;
#(
  parameter int depth_p = 8,
  parameter int width_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               yumi_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output logic               full_o
);
  localparam int ptr_w_lp = depth_p > 1 ? $clog2(depth_p) : 1;
  localparam int cnt_w_lp = $clog2(depth_p + 1);
  logic [width_p-1:0] mem_r [depth_p];
  logic [ptr_w_lp-1:0] rptr_r, wptr_r;
  logic [cnt_w_lp-1:0] cnt_r, cnt_n;
  logic empty_r;
  assign cnt_n = cnt_r + cnt_w_lp'(v_i) - cnt_w_lp'(yumi_i);
  assign v_o = ~empty_r;
  assign data_o = mem_r[rptr_r];
  always_ff @(posedge clk_i)
    if (v_i) mem_r[wptr_r] <= data_i;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      rptr_r <= '0;
      wptr_r <= '0;
      cnt_r <= '0;
      full_o <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      if (v_i) wptr_r <= (wptr_r == ptr_w_lp'(depth_p - 1)) ? '0 : wptr_r + 1'b1;
      if (yumi_i) rptr_r <= (rptr_r == ptr_w_lp'(depth_p - 1)) ? '0 : rptr_r + 1'b1;
      cnt_r <= cnt_n;
      full_o <= cnt_n == cnt_w_lp'(depth_p);
      empty_r <= cnt_n == '0;
    end
endmodule

// File: rtl/bsg_nasti_master_arbiter.sv
// bsg_nasti_master_arbiter: round-robin merge of tunnel requesters onto one nasti master, with in-order read response routing
module bsg_nasti_master_arbiter
  import bsg_nasti_pkg::*;
#(
  parameter int num_src_p = 4,
  parameter int max_out_p = 8,
  localparam int src_id_width_lp = $clog2(num_src_p)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [num_src_p-1:0]          src_req_valid_i,
  input  bsg_tun_dmx_t [num_src_p-1:0]  src_req_data_i,
  output logic [num_src_p-1:0]          src_req_yumi_o,
  output logic                          req_valid_o,
  output bsg_tun_dmx_t                  req_data_o,
  input  logic                          req_yumi_i,
  input  logic                          resp_valid_i,
  input  bsg_tun_dmx_t                  resp_data_i,
  output logic                          resp_yumi_o,
  output logic [num_src_p-1:0]          src_resp_valid_o,
  output bsg_tun_dmx_t                  src_resp_data_o,
  input  logic [num_src_p-1:0]          src_resp_yumi_i,
  output logic                          error_o
);
  typedef enum logic {e_idle, e_locked} state_e;
  state_e state_r;
  logic [src_id_width_lp-1:0] rr_ptr_r, grant_r, winner, sel, head;
  logic [num_src_p-1:0] elig;
  logic found, accept, push, fifo_full, fifo_v;
  for (genvar k = 0; k < num_src_p; k++)
    assign elig[k] = src_req_valid_i[k] & (~bsg_nasti_req_is_read(src_req_data_i[k]) | ~fifo_full);
  always_comb begin
    winner = '0;
    found = 1'b0;
    for (int i = num_src_p - 1; i >= 0; i--)
      if (elig[(int'(rr_ptr_r) + i) % num_src_p]) begin
        winner = src_id_width_lp'((int'(rr_ptr_r) + i) % num_src_p);
        found = 1'b1;
      end
  end
  assign sel = (state_r == e_locked) ? grant_r : winner;
  assign req_valid_o = ~reset_i & ((state_r == e_locked) | found);
  assign req_data_o = src_req_data_i[sel];
  assign accept = req_valid_o & req_yumi_i;
  assign push = accept & bsg_nasti_req_is_read(req_data_o);
  assign src_req_yumi_o = accept ? num_src_p'(1) << sel : '0;
  assign src_resp_valid_o = (~reset_i & resp_valid_i & fifo_v) ? num_src_p'(1) << head : '0;
  assign resp_yumi_o = ~reset_i & fifo_v & src_resp_yumi_i[head];
  assign src_resp_data_o = resp_data_i;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_r <= e_idle;
      grant_r <= '0;
      rr_ptr_r <= '0;
      error_o <= 1'b0;
    end else begin
      state_r <= (req_valid_o & ~req_yumi_i) ? e_locked : e_idle;
      if (req_valid_o & ~req_yumi_i) grant_r <= sel;
      if (accept) rr_ptr_r <= (sel == src_id_width_lp'(num_src_p - 1)) ? '0 : sel + 1'b1;
      if (resp_valid_i & ~fifo_v) error_o <= 1'b1;
    end
  bsg_nasti_arb_id_fifo #(.depth_p(max_out_p), .width_p(src_id_width_lp)) fifo (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .v_i(push),
    .data_i(sel),
    .yumi_i(resp_yumi_o),
    .v_o(fifo_v),
    .data_o(head),
    .full_o(fifo_full)
  );
endmodule

// File: tb/tb_bsg_nasti_master_arbiter.sv
// tb_bsg_nasti_master_arbiter: table vectors, corner sequences and a randomized model check
module tb_bsg_nasti_master_arbiter;
  import bsg_nasti_pkg::*;
  localparam int n = 4;
  localparam int depth = 8;
  logic clk_i = 1'b0, reset_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic [n-1:0] src_req_valid, src_req_yumi, src_resp_valid, src_resp_yumi;
  bsg_tun_dmx_t [n-1:0] src_req_data;
  logic req_valid, req_yumi, resp_valid, resp_yumi, error;
  bsg_tun_dmx_t req_data, resp_data, src_resp_data;
  logic [n-1:0] b_src_req_valid, b_src_req_yumi, b_src_resp_valid, b_src_resp_yumi;
  bsg_tun_dmx_t [n-1:0] b_src_req_data;
  logic b_req_valid, b_req_yumi, b_resp_valid, b_resp_yumi, b_error;
  bsg_tun_dmx_t b_req_data, b_src_resp_data;
  int errors = 0, checks = 0;
  bsg_nasti_master_arbiter #(.num_src_p(n), .max_out_p(depth)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .src_req_valid_i(src_req_valid), .src_req_data_i(src_req_data), .src_req_yumi_o(src_req_yumi),
    .req_valid_o(req_valid), .req_data_o(req_data), .req_yumi_i(req_yumi),
    .resp_valid_i(resp_valid), .resp_data_i(resp_data), .resp_yumi_o(resp_yumi),
    .src_resp_valid_o(src_resp_valid), .src_resp_data_o(src_resp_data), .src_resp_yumi_i(src_resp_yumi),
    .error_o(error));
  bsg_nasti_master_arbiter #(.num_src_p(n), .max_out_p(2)) dut_b (
    .clk_i(clk_i), .reset_i(reset_i),
    .src_req_valid_i(b_src_req_valid), .src_req_data_i(b_src_req_data), .src_req_yumi_o(b_src_req_yumi),
    .req_valid_o(b_req_valid), .req_data_o(b_req_data), .req_yumi_i(b_req_yumi),
    .resp_valid_i(b_resp_valid), .resp_data_i(resp_data), .resp_yumi_o(b_resp_yumi),
    .src_resp_valid_o(b_src_resp_valid), .src_resp_data_o(b_src_resp_data), .src_resp_yumi_i(b_src_resp_yumi),
    .error_o(b_error));
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic bsg_tun_dmx_t mk(int k, bit rd);
    bsg_tun_dmx_t r;
    r.op = rd ? e_nasti_read : e_nasti_write;
    r.addr = 32'h1000 + 32'(k) * 32'h10;
    r.data = 32'hd0 + 32'(k);
    return r;
  endfunction
  function automatic bsg_tun_dmx_t rnd_req();
    bsg_tun_dmx_t r;
    r.op = $urandom_range(1) ? e_nasti_write : e_nasti_read;
    r.addr = $urandom;
    r.data = $urandom;
    return r;
  endfunction
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask
  task automatic quiet();
    src_req_valid = '0; req_yumi = 0; resp_valid = 0; src_resp_yumi = '0; resp_data = '0;
    b_src_req_valid = '0; b_req_yumi = 0; b_resp_valid = 0; b_src_resp_yumi = '0;
    for (int k = 0; k < n; k++) begin
      src_req_data[k] = mk(k, 1);
      b_src_req_data[k] = mk(k, 1);
    end
  endtask
  task automatic do_reset();
    quiet();
    reset_i = 1;
    tick();
    reset_i = 0;
  endtask
  typedef struct {
    logic [n-1:0] v;
    logic ry, rv;
    logic [n-1:0] sry;
    logic e_rv;
    int e_src;
    logic [n-1:0] e_yumi, e_rsv;
    logic e_ryumi;
  } vec_t;
  vec_t tbl[9];
  bit [n-1:0] sv;
  bsg_tun_dmx_t sd[n];
  int q[$];
  int m_ptr, m_grant, e_sel;
  bit m_locked, m_err, e_found, e_ryumi;
  logic [n-1:0] e_yumi, e_rsv;
  initial begin
    // sources 0 and 2 alternate, then responses drain back in grant order
    tbl[0] = '{4'b0101, 1, 0, 4'b0000, 1, 0, 4'b0001, 4'b0000, 0};
    tbl[1] = '{4'b0101, 1, 0, 4'b0000, 1, 2, 4'b0100, 4'b0000, 0};
    tbl[2] = '{4'b0101, 1, 0, 4'b0000, 1, 0, 4'b0001, 4'b0000, 0};
    tbl[3] = '{4'b0101, 1, 0, 4'b0000, 1, 2, 4'b0100, 4'b0000, 0};
    tbl[4] = '{4'b0000, 0, 1, 4'b1111, 0, -1, 4'b0000, 4'b0001, 1};
    tbl[5] = '{4'b0000, 0, 1, 4'b1111, 0, -1, 4'b0000, 4'b0100, 1};
    tbl[6] = '{4'b0000, 0, 1, 4'b1111, 0, -1, 4'b0000, 4'b0001, 1};
    tbl[7] = '{4'b0000, 0, 1, 4'b1111, 0, -1, 4'b0000, 4'b0100, 1};
    tbl[8] = '{4'b0000, 0, 0, 4'b1111, 0, -1, 4'b0000, 4'b0000, 0};
    do_reset();
    #1;
    chk("reset_req_valid", req_valid, 0);
    chk("reset_yumi", src_req_yumi, 0);
    chk("reset_resp_valid", src_resp_valid, 0);
    chk("reset_resp_yumi", resp_yumi, 0);
    chk("reset_error", error, 0);
    tick();
    for (int i = 0; i < 9; i++) begin
      src_req_valid = tbl[i].v; req_yumi = tbl[i].ry; resp_valid = tbl[i].rv;
      src_resp_yumi = tbl[i].sry; resp_data = rnd_req();
      #1;
      chk($sformatf("tbl%0d_req_valid", i), req_valid, tbl[i].e_rv);
      chk($sformatf("tbl%0d_src_yumi", i), src_req_yumi, tbl[i].e_yumi);
      if (tbl[i].e_src >= 0) chk($sformatf("tbl%0d_req_data", i), req_data, mk(tbl[i].e_src, 1));
      chk($sformatf("tbl%0d_resp_valid", i), src_resp_valid, tbl[i].e_rsv);
      chk($sformatf("tbl%0d_resp_yumi", i), resp_yumi, tbl[i].e_ryumi);
      chk($sformatf("tbl%0d_resp_data", i), src_resp_data, resp_data);
      tick();
    end
    chk("tbl_error", error, 0);
    // lock holds source 1 while source 0 arrives late
    do_reset();
    src_req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) src_req_valid = 4'b0011;
      #1;
      chk($sformatf("lock%0d_data", c), req_data, mk(1, 1));
      chk($sformatf("lock%0d_yumi", c), src_req_yumi, 0);
      tick();
    end
    req_yumi = 1;
    #1;
    chk("lock_accept_data", req_data, mk(1, 1));
    chk("lock_accept_yumi", src_req_yumi, 4'b0010);
    tick();
    src_req_valid = 4'b0001; req_yumi = 0;
    #1;
    chk("lock_next_data", req_data, mk(0, 1));
    chk("lock_next_valid", req_valid, 1);
    tick();
    // depth-2 instance: full FIFO blocks reads but not writes
    do_reset();
    b_src_req_data[3] = mk(3, 0);
    b_src_req_valid = 4'b0001; b_req_yumi = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("full_rd%0d_yumi", c), b_src_req_yumi, 4'b0001);
      tick();
    end
    #1;
    chk("full_blocked_valid", b_req_valid, 0);
    chk("full_blocked_yumi", b_src_req_yumi, 0);
    tick();
    b_src_req_valid = 4'b1001;
    #1;
    chk("full_write_data", b_req_data, mk(3, 0));
    chk("full_write_yumi", b_src_req_yumi, 4'b1000);
    tick();
    b_src_req_valid = 4'b0001; b_resp_valid = 1; b_src_resp_yumi = 4'b0001;
    #1;
    chk("full_pop_valid", b_req_valid, 0);
    chk("full_pop_resp_yumi", b_resp_yumi, 1);
    chk("full_pop_resp_vec", b_src_resp_valid, 4'b0001);
    tick();
    b_resp_valid = 0; b_src_resp_yumi = '0;
    #1;
    chk("full_unblock_valid", b_req_valid, 1);
    chk("full_unblock_yumi", b_src_req_yumi, 4'b0001);
    tick();
    // response stall, then orphan response and sticky error
    do_reset();
    src_req_valid = 4'b0010; req_yumi = 1;
    #1;
    chk("stall_issue_yumi", src_req_yumi, 4'b0010);
    tick();
    src_req_valid = '0; req_yumi = 0; resp_valid = 1; src_resp_yumi = '0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("stall%0d_vec", c), src_resp_valid, 4'b0010);
      chk($sformatf("stall%0d_yumi", c), resp_yumi, 0);
      tick();
    end
    src_resp_yumi = 4'b0010;
    #1;
    chk("stall_release_yumi", resp_yumi, 1);
    tick();
    src_resp_yumi = 4'b1111;
    #1;
    chk("orphan_yumi", resp_yumi, 0);
    chk("orphan_vec", src_resp_valid, 0);
    chk("orphan_error_pre", error, 0);
    tick();
    resp_valid = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("orphan_error%0d", c), error, 1);
      tick();
    end
    do_reset();
    #1;
    chk("orphan_error_cleared", error, 0);
    tick();
    // asynchronous reset while locked with three tags queued
    src_req_valid = 4'b0111; req_yumi = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("areset_fill%0d", c), src_req_yumi, n'(1) << c);
      tick();
    end
    src_req_data[3] = mk(3, 0);
    src_req_valid = 4'b1000; req_yumi = 0; resp_valid = 1; src_resp_yumi = '0;
    #1;
    chk("areset_pre_vec", src_resp_valid, 4'b0001);
    tick();
    #1;
    chk("areset_locked_data", req_data, mk(3, 0));
    reset_i = 1; req_yumi = 1; src_resp_yumi = 4'b1111;
    #1;
    chk("areset_req_valid", req_valid, 0);
    chk("areset_src_yumi", src_req_yumi, 0);
    chk("areset_resp_vec", src_resp_valid, 0);
    chk("areset_resp_yumi", resp_yumi, 0);
    #1;
    reset_i = 0;
    src_req_data[1] = mk(1, 1); src_req_data[3] = mk(3, 1);
    src_req_valid = 4'b1010; req_yumi = 0;
    #1;
    chk("areset_ptr_zero", req_data, mk(1, 1));
    chk("areset_fifo_empty_vec", src_resp_valid, 0);
    chk("areset_fifo_empty_yumi", resp_yumi, 0);
    // randomized run against a queue-based model
    do_reset();
    sv = '0; q.delete(); m_ptr = 0; m_locked = 0; m_err = 0; m_grant = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < n; k++)
        if (!sv[k] && $urandom_range(2) == 0) begin
          sv[k] = 1;
          sd[k] = rnd_req();
        end
      src_req_valid = sv;
      for (int k = 0; k < n; k++) src_req_data[k] = sd[k];
      req_yumi = 1'($urandom_range(1));
      resp_valid = q.size() > 0 ? ($urandom_range(3) != 0) : ($urandom_range(15) == 0);
      src_resp_yumi = n'($urandom);
      resp_data = rnd_req();
      #1;
      e_found = 0; e_sel = 0;
      if (m_locked) begin
        e_found = 1;
        e_sel = m_grant;
      end else
        for (int o = 0; o < n; o++)
          if (!e_found && sv[(m_ptr + o) % n] && (sd[(m_ptr + o) % n].op == e_nasti_write || q.size() < depth)) begin
            e_found = 1;
            e_sel = (m_ptr + o) % n;
          end
      e_yumi = (e_found && req_yumi) ? n'(1) << e_sel : '0;
      e_rsv = (resp_valid && q.size() > 0) ? n'(1) << q[0] : '0;
      e_ryumi = q.size() > 0 && src_resp_yumi[q[0]];
      chk("rnd_req_valid", req_valid, e_found);
      if (e_found) chk("rnd_req_data", req_data, sd[e_sel]);
      chk("rnd_src_yumi", src_req_yumi, e_yumi);
      chk("rnd_resp_vec", src_resp_valid, e_rsv);
      chk("rnd_resp_yumi", resp_yumi, e_ryumi);
      chk("rnd_error", error, m_err);
      if (resp_valid && q.size() == 0) m_err = 1;
      if (e_ryumi) void'(q.pop_front());
      if (e_found && req_yumi) begin
        if (sd[e_sel].op == e_nasti_read) q.push_back(e_sel);
        m_ptr = (e_sel + 1) % n;
        sv[e_sel] = 0;
      end
      m_locked = e_found && !req_yumi;
      if (m_locked) m_grant = e_sel;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
